alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one 8-bit ALU (FORWARD/ADD/AND/OR/SLL/SRL/SRA/ROR, 3-bit select, ZERO flag) between two requesters.
//  Round-robin grant, latches the winner's operands into registers that drive the ALU, waits a fixed settle
//  time, then returns the registered RESULT/ZERO tagged with the requester ID.
//  Sits between the ALU and its clients, e.g. the main datapath and a multi-cycle helper unit.
// PARAMETERS
//  DATA_W         8   operand/result width
//  SEL_W          3   ALU select width
//  SETTLE_CYCLES  2   cycles operands are held on the ALU before capture; legal 1..15
// PORTS
//  CLK         in   1       clock, rising edge
//  RESET       in   1       synchronous, active-high
//  REQ0/REQ1   in   1       request from requester 0/1; held high until its GNT is seen
//  OP0/OP1     in   SEL_W   ALU select, stable while REQn high
//  A0/A1       in   DATA_W  operand 1 (DATA1), stable while REQn high
//  B0/B1       in   DATA_W  operand 2 (DATA2), stable while REQn high
//  GNT0/GNT1   out  1       one-cycle accept pulse; operands captured on that edge
//  ALU_DATA1   out  DATA_W  to ALU DATA1 (registered)
//  ALU_DATA2   out  DATA_W  to ALU DATA2 (registered)
//  ALU_SELECT  out  SEL_W   to ALU SELECT (registered)
//  ALU_RESULT  in   DATA_W  from ALU RESULT
//  ALU_ZERO    in   1       from ALU ZERO
//  RES_VALID   out  1       one-cycle pulse, result fields valid
//  RES_ID      out  1       requester that owns the result (0/1)
//  RES_DATA    out  DATA_W  captured ALU_RESULT
//  RES_ZERO    out  1       captured ALU_ZERO
//  BUSY        out  1       high in EXEC
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, counter 0, last_grant=1 (requester 0 wins first tie).
//  States: IDLE, EXEC. All outputs registered.
//  IDLE, edge with REQ0|REQ1: winner = sole requester, or on tie the one != last_grant.
//   Load ALU_DATA1/ALU_DATA2/ALU_SELECT from winner's A/B/OP; GNTwinner=1 for that one cycle;
//   last_grant=winner; cnt=SETTLE_CYCLES; state->EXEC; BUSY=1.
//  IDLE, no request: hold ALU_* outputs at previous values; GNT*=0, RES_VALID=0.
//  EXEC: requests ignored (no GNT). Each edge cnt-=1; on edge where cnt==1: RES_DATA=ALU_RESULT,
//   RES_ZERO=ALU_ZERO, RES_ID=last_grant, RES_VALID=1 (one cycle), state->IDLE, BUSY=0.
//  Latency: RES_VALID asserts exactly SETTLE_CYCLES cycles after GNT. Issue interval SETTLE_CYCLES+1.
//  RES_DATA/RES_ZERO/RES_ID hold their values after RES_VALID drops until the next capture.
//  Requester must drop REQ (or present the next op) by the cycle after GNT; a REQ still high on
//   return to IDLE is a new request.
//  Single persistent requester with the other idle: granted every issue slot (no forced idle).
//  Both always requesting: grants strictly alternate 0,1,0,1...
//  Operands are never re-sampled during EXEC; changes on A/B/OP then have no effect.
//  RESET in EXEC: operation abandoned, no RES_VALID, all state to reset values on that edge.
//  Counter width 4 bits; no wrap since SETTLE_CYCLES<=15 and load only in IDLE.
// TESTING
//  REQ0 OP=001 A0=25 B0=41, SETTLE=2 -> GNT0 1 cycle, RES_VALID 2 cycles later, RES_ID=0 RES_DATA=66 RES_ZERO=0.
//  REQ0,REQ1 same edge after reset (OP0=010 A0=0x0F B0=0xF0; OP1=011 A1=0x0F B1=0xF0) -> GNT0 first,
//   RES_DATA=0x00 RES_ZERO=1; then GNT1, RES_ID=1 RES_DATA=0xFF RES_ZERO=0.
//  Both held high 6 issues -> GNT order 0,1,0,1,0,1; no GNT while BUSY; issue interval 3 cycles.
//  REQ1 only held high, OP1=100 A1=0x81 B1=1 -> GNT1 every 3 cycles, each RES_DATA=0x02.
//  RESET pulsed 1 cycle after GNT0 -> no RES_VALID, outputs 0, next tie grants requester 0.
//  SETTLE_CYCLES=1 instance, OP=111 A=0x01 B=1 -> RES_VALID next cycle after GNT, RES_DATA=0x80.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: latches the winner's
// operands onto registered ALU inputs, waits SETTLE_CYCLES, then returns the tagged result.
module alu_share_arbiter #(
    parameter int DATA_W        = 8,
    parameter int SEL_W         = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic [SEL_W-1:0]  OP0,
    input  logic [SEL_W-1:0]  OP1,
    input  logic [DATA_W-1:0] A0,
    input  logic [DATA_W-1:0] A1,
    input  logic [DATA_W-1:0] B0,
    input  logic [DATA_W-1:0] B1,
    output logic              GNT0,
    output logic              GNT1,
    output logic [DATA_W-1:0] ALU_DATA1,
    output logic [DATA_W-1:0] ALU_DATA2,
    output logic [SEL_W-1:0]  ALU_SELECT,
    input  logic [DATA_W-1:0] ALU_RESULT,
    input  logic              ALU_ZERO,
    output logic              RES_VALID,
    output logic              RES_ID,
    output logic [DATA_W-1:0] RES_DATA,
    output logic              RES_ZERO,
    output logic              BUSY
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    typedef enum logic [0:0] {IDLE, EXEC} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              last_grant, last_grant_nx;
    logic              winner;
    logic [DATA_W-1:0] data1_nx, data2_nx, res_data_nx;
    logic [SEL_W-1:0]  sel_nx;
    logic              gnt0_nx, gnt1_nx, valid_nx, id_nx, zero_nx, busy_nx;

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        last_grant_nx = last_grant;
        winner        = 1'b0;
        data1_nx      = ALU_DATA1;
        data2_nx      = ALU_DATA2;
        sel_nx        = ALU_SELECT;
        gnt0_nx       = 1'b0;
        gnt1_nx       = 1'b0;
        valid_nx      = 1'b0;
        id_nx         = RES_ID;
        res_data_nx   = RES_DATA;
        zero_nx       = RES_ZERO;
        busy_nx       = BUSY;
        case (state)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    // On a tie the requester that did not win last time goes first.
                    winner        = (REQ0 && REQ1) ? ~last_grant : REQ1;
                    data1_nx      = winner ? A1  : A0;
                    data2_nx      = winner ? B1  : B0;
                    sel_nx        = winner ? OP1 : OP0;
                    gnt0_nx       = ~winner;
                    gnt1_nx       = winner;
                    last_grant_nx = winner;
                    cnt_nx        = SETTLE_LOAD;
                    state_nx      = EXEC;
                    busy_nx       = 1'b1;
                end
            end
            EXEC: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    res_data_nx = ALU_RESULT;
                    zero_nx     = ALU_ZERO;
                    id_nx       = last_grant;
                    valid_nx    = 1'b1;
                    state_nx    = IDLE;
                    busy_nx     = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            ALU_DATA1  <= '0;
            ALU_DATA2  <= '0;
            ALU_SELECT <= '0;
            GNT0       <= 1'b0;
            GNT1       <= 1'b0;
            RES_VALID  <= 1'b0;
            RES_ID     <= 1'b0;
            RES_DATA   <= '0;
            RES_ZERO   <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_grant <= last_grant_nx;
            ALU_DATA1  <= data1_nx;
            ALU_DATA2  <= data2_nx;
            ALU_SELECT <= sel_nx;
            GNT0       <= gnt0_nx;
            GNT1       <= gnt1_nx;
            RES_VALID  <= valid_nx;
            RES_ID     <= id_nx;
            RES_DATA   <= res_data_nx;
            RES_ZERO   <= zero_nx;
            BUSY       <= busy_nx;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a behavioural ALU closes the loop on two instances
// (settle 2 and settle 1); every check is an immediate assertion against hand-computed values.
module tb_alu_share_arbiter;

    logic       CLK;
    logic       RESET;

    // Instance with SETTLE_CYCLES=2
    logic       REQ0, REQ1;
    logic [2:0] OP0, OP1;
    logic [7:0] A0, A1, B0, B1;
    logic       GNT0, GNT1;
    logic [7:0] ALU_DATA1, ALU_DATA2;
    logic [2:0] ALU_SELECT;
    logic [7:0] ALU_RESULT;
    logic       ALU_ZERO;
    logic       RES_VALID, RES_ID, RES_ZERO, BUSY;
    logic [7:0] RES_DATA;

    // Instance with SETTLE_CYCLES=1
    logic       s_req0, s_req1;
    logic [2:0] s_op0, s_op1;
    logic [7:0] s_a0, s_a1, s_b0, s_b1;
    logic       s_gnt0, s_gnt1;
    logic [7:0] s_d1, s_d2;
    logic [2:0] s_sel;
    logic [7:0] s_result;
    logic       s_zero;
    logic       s_valid, s_id, s_res_zero, s_busy;
    logic [7:0] s_res_data;

    int n_cmp = 0;
    int n_mis = 0;

    alu_share_arbiter #(.DATA_W(8), .SEL_W(3), .SETTLE_CYCLES(2)) u_dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .REQ1(REQ1), .OP0(OP0), .OP1(OP1),
        .A0(A0), .A1(A1), .B0(B0), .B1(B1),
        .GNT0(GNT0), .GNT1(GNT1),
        .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
        .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO),
        .RES_VALID(RES_VALID), .RES_ID(RES_ID), .RES_DATA(RES_DATA),
        .RES_ZERO(RES_ZERO), .BUSY(BUSY)
    );

    alu_share_arbiter #(.DATA_W(8), .SEL_W(3), .SETTLE_CYCLES(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET),
        .REQ0(s_req0), .REQ1(s_req1), .OP0(s_op0), .OP1(s_op1),
        .A0(s_a0), .A1(s_a1), .B0(s_b0), .B1(s_b1),
        .GNT0(s_gnt0), .GNT1(s_gnt1),
        .ALU_DATA1(s_d1), .ALU_DATA2(s_d2), .ALU_SELECT(s_sel),
        .ALU_RESULT(s_result), .ALU_ZERO(s_zero),
        .RES_VALID(s_valid), .RES_ID(s_id), .RES_DATA(s_res_data),
        .RES_ZERO(s_res_zero), .BUSY(s_busy)
    );

    function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        logic [7:0]  r;
        logic [15:0] dbl;
        dbl = {a, a};
        case (op)
            3'd0:    r = a;
            3'd1:    r = a + b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a << b[2:0];
            3'd5:    r = a >> b[2:0];
            3'd6:    r = 8'($signed(a) >>> b[2:0]);
            default: r = dbl[7:0] >> 0 == 8'h00 ? 8'h00 : 8'(dbl >> b[2:0]);
        endcase
        return {(r == 8'h00), r};
    endfunction

    assign {ALU_ZERO, ALU_RESULT} = alu_model(ALU_SELECT, ALU_DATA1, ALU_DATA2);
    assign {s_zero, s_result}     = alu_model(s_sel, s_d1, s_d2);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET = 1'b1;
        REQ0 = 0; REQ1 = 0; OP0 = 0; OP1 = 0; A0 = 0; A1 = 0; B0 = 0; B1 = 0;
        s_req0 = 0; s_req1 = 0; s_op0 = 0; s_op1 = 0; s_a0 = 0; s_a1 = 0; s_b0 = 0; s_b1 = 0;
        tick;
        tick;
        RESET = 1'b0;

        // Reset state
        chk("rst_gnt", {GNT0, GNT1}, 0);
        chk("rst_valid", RES_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_alu", {ALU_DATA1, ALU_DATA2, ALU_SELECT}, 0);
        chk("rst_res", {RES_ID, RES_DATA, RES_ZERO}, 0);
        chk("rst1_outs", {s_gnt0, s_gnt1, s_valid, s_busy, s_d1}, 0);

        // Single request: 25 + 41 = 66
        REQ0 = 1; OP0 = 3'b001; A0 = 8'd25; B0 = 8'd41;
        tick;
        chk("add_gnt0", GNT0, 1);
        chk("add_gnt1", GNT1, 0);
        chk("add_busy", BUSY, 1);
        chk("add_alu_in", {ALU_DATA1, ALU_DATA2, ALU_SELECT}, {8'd25, 8'd41, 3'b001});
        chk("add_valid_early0", RES_VALID, 0);
        REQ0 = 0;
        tick;
        chk("add_gnt_drop", GNT0, 0);
        chk("add_valid_early1", RES_VALID, 0);
        chk("add_busy_mid", BUSY, 1);
        tick;
        chk("add_valid", RES_VALID, 1);
        chk("add_res", {RES_ID, RES_DATA, RES_ZERO}, {1'b0, 8'd66, 1'b0});
        chk("add_busy_end", BUSY, 0);
        tick;
        chk("add_valid_drop", RES_VALID, 0);
        chk("add_res_hold", RES_DATA, 8'd66);
        chk("add_alu_hold", ALU_DATA1, 8'd25);

        // Tie right after reset: requester 0 first, then 1
        RESET = 1;
        tick;
        RESET = 0;
        REQ0 = 1; OP0 = 3'b010; A0 = 8'h0F; B0 = 8'hF0;
        REQ1 = 1; OP1 = 3'b011; A1 = 8'h0F; B1 = 8'hF0;
        tick;
        chk("tie_gnt", {GNT0, GNT1}, 2'b10);
        chk("tie_sel0", ALU_SELECT, 3'b010);
        REQ0 = 0;
        tick;
        chk("tie_no_gnt_busy", {GNT0, GNT1}, 0);
        tick;
        chk("tie_res0", {RES_VALID, RES_ID, RES_DATA, RES_ZERO}, {1'b1, 1'b0, 8'h00, 1'b1});
        tick;
        chk("tie_gnt1", {GNT0, GNT1}, 2'b01);
        chk("tie_sel1", ALU_SELECT, 3'b011);
        REQ1 = 0;
        tick;
        tick;
        chk("tie_res1", {RES_VALID, RES_ID, RES_DATA, RES_ZERO}, {1'b1, 1'b1, 8'hFF, 1'b0});

        // Both held high: strict alternation, interval 3
        REQ0 = 1; REQ1 = 1;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("alt_gnt", {GNT0, GNT1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick;
            chk("alt_quiet", {GNT0, GNT1, BUSY, RES_VALID}, 4'b0010);
            tick;
            chk("alt_res", {RES_VALID, RES_ID, RES_DATA},
                (i % 2 == 0) ? {1'b1, 1'b0, 8'h00} : {1'b1, 1'b1, 8'hFF});
        end

        // Sole persistent requester 1, SLL 0x81 by 1; operand changes during EXEC ignored
        REQ0 = 0; REQ1 = 1; OP1 = 3'b100; A1 = 8'h81; B1 = 8'd1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("solo_gnt", {GNT0, GNT1}, 2'b01);
            A1 = 8'h03; B1 = 8'd2; OP1 = 3'b001;
            tick;
            chk("solo_alu_held", {ALU_DATA1, ALU_DATA2, ALU_SELECT}, {8'h81, 8'd1, 3'b100});
            tick;
            chk("solo_res", {RES_VALID, RES_ID, RES_DATA, RES_ZERO}, {1'b1, 1'b1, 8'h02, 1'b0});
            A1 = 8'h81; B1 = 8'd1; OP1 = 3'b100;
        end

        // Reset one cycle after GNT0 abandons the op; next tie goes to 0
        REQ1 = 0; REQ0 = 1; OP0 = 3'b001; A0 = 8'd25; B0 = 8'd41;
        tick;
        chk("abort_gnt0", {GNT0, GNT1}, 2'b10);
        REQ0 = 0; RESET = 1;
        tick;
        RESET = 0;
        chk("abort_outs", {GNT0, GNT1, BUSY, RES_VALID, ALU_DATA1, ALU_DATA2, ALU_SELECT}, 0);
        chk("abort_res", {RES_ID, RES_DATA, RES_ZERO}, 0);
        tick;
        chk("abort_no_valid1", RES_VALID, 0);
        tick;
        chk("abort_no_valid2", RES_VALID, 0);
        REQ0 = 1; REQ1 = 1;
        tick;
        chk("abort_tie_gnt", {GNT0, GNT1}, 2'b10);
        REQ0 = 0; REQ1 = 0;
        tick;
        tick;
        chk("abort_tie_res", {RES_VALID, RES_ID, RES_DATA}, {1'b1, 1'b0, 8'd66});

        // SETTLE_CYCLES=1: ROR 0x01 by 1 -> 0x80, result the cycle after grant
        s_req0 = 1; s_op0 = 3'b111; s_a0 = 8'h01; s_b0 = 8'd1;
        tick;
        chk("s1_gnt", {s_gnt0, s_gnt1, s_busy, s_valid}, 4'b1010);
        s_req0 = 0;
        tick;
        chk("s1_res", {s_valid, s_id, s_res_data, s_res_zero, s_busy}, {1'b1, 1'b0, 8'h80, 1'b0, 1'b0});
        tick;
        chk("s1_valid_drop", {s_valid, s_res_data}, {1'b0, 8'h80});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
